// File: rtl/vcu_rst_pkg.sv
// Shared types and defaults for the reset sequencer.
// Optional watchdog is enabled with `define RST_SEQ_WDT_EN.
package vcu_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SOFT    = 2'd3
  } seq_state_e;

  localparam int DEF_STAGES      = 3;
  localparam int DEF_STAGE_DLY   = 1000;
  localparam int DEF_LOCK_FILT   = 16;
  localparam int DEF_SOFT_HOLD   = 64;
  localparam int DEF_WDT_TIMEOUT = 65536;

  // One counter width serves every timed interval in the sequencer.
  function automatic int cnt_width(input int dly, input int hold,
                                   input int filt, input int wdt);
    int m;
    m = dly;
    if (hold > m) m = hold;
    if (filt > m) m = filt;
    if (wdt > m)  m = wdt;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/vcu_rst_seq_lock_filt.sv
// Consecutive-sample PLL lock filter: locked_stable pulses on the
// LOCK_FILT-th consecutive high sample while clr is low.
module vcu_lock_filt
  import vcu_rst_pkg::*;
#(
  parameter int LOCK_FILT = DEF_LOCK_FILT
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  input  logic pll_locked,
  output logic locked_stable
);

  localparam int W = $clog2(LOCK_FILT) + 1;

  logic [W-1:0] cnt;

  // Qualifying on the current sample lets the FSM leave HOLD on the very
  // edge that delivers the final high sample.
  assign locked_stable = pll_locked && !clr && (cnt == W'(LOCK_FILT - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      cnt <= '0;
    else if (clr || !pll_locked || locked_stable)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vcu_rst_seq.sv
// Power-up reset sequencer: releases STAGES active-low resets in order once
// PLL lock is stable. `define RST_SEQ_WDT_EN builds the RUN-state watchdog.
module vcu_rst_seq
  import vcu_rst_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int LOCK_FILT   = DEF_LOCK_FILT,
  parameter int SOFT_HOLD   = DEF_SOFT_HOLD,
  parameter int WDT_TIMEOUT = DEF_WDT_TIMEOUT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  input  logic              wdt_kick,
  output logic [STAGES-1:0] rst_n_out,
  output logic              seq_done,
  output logic              wdt_fired
);

  localparam int CW = cnt_width(STAGE_DLY, SOFT_HOLD, LOCK_FILT, WDT_TIMEOUT);

  seq_state_e        state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [3:0]        stg, stg_nx;
  logic [STAGES-1:0] rst_nx;
  logic              done_nx;
  logic              lock_ok;
  logic              wdt_exp;

  vcu_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_lock_filt (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clr           (state != HOLD),
    .pll_locked    (pll_locked),
    .locked_stable (lock_ok)
  );

`ifdef RST_SEQ_WDT_EN
  // In RUN the shared counter is the watchdog; a kick on the expiry edge wins.
  assign wdt_exp = (state == RUN) && !wdt_kick && (cnt == CW'(WDT_TIMEOUT - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      wdt_fired <= 1'b0;
    else if (wdt_exp && pll_locked)
      wdt_fired <= 1'b1;
  end
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign wdt_exp     = 1'b0;
  assign wdt_fired   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stg_nx   = stg;
    unique case (state)
      HOLD: begin
        if (lock_ok) state_nx = RELEASE;
      end
      RELEASE: begin
        if (!pll_locked)
          state_nx = HOLD;
        else if (soft_rst_req)
          state_nx = SOFT;
        else if (cnt == CW'(STAGE_DLY - 1)) begin
          cnt_nx = '0;
          if (stg == 4'(STAGES - 1))
            state_nx = RUN;
          else
            stg_nx = stg + 1'b1;
        end else
          cnt_nx = cnt + 1'b1;
      end
      RUN: begin
        if (!pll_locked)
          state_nx = HOLD;
        else if (wdt_exp || soft_rst_req)
          state_nx = SOFT;
`ifdef RST_SEQ_WDT_EN
        else
          cnt_nx = wdt_kick ? '0 : cnt + 1'b1;
`endif
      end
      SOFT: begin
        if (cnt == CW'(SOFT_HOLD - 1))
          state_nx = HOLD;
        else
          cnt_nx = cnt + 1'b1;
      end
      default: state_nx = HOLD;
    endcase

    if (state_nx != state) begin
      cnt_nx = '0;
      stg_nx = '0;
    end

    // Outputs are a thermometer of the released stage index, so stages can
    // only ever drop together.
    rst_nx = '0;
    for (int i = 0; i < STAGES; i++)
      if ((state_nx == RUN) || ((state_nx == RELEASE) && (4'(i) <= stg_nx)))
        rst_nx[i] = 1'b1;
    done_nx = (state_nx == RUN);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= HOLD;
      cnt       <= '0;
      stg       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stg       <= stg_nx;
      rst_n_out <= rst_nx;
      seq_done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_vcu_rst_seq.sv
// Bench for vcu_rst_seq: edge-time model plus directed scenarios.
// Watchdog scenarios are built when RST_SEQ_WDT_EN is defined.
module tb_vcu_rst_seq;

  localparam int STAGES    = 3;
  localparam int STAGE_DLY = 1000;
  localparam int LOCK_FILT = 16;
  localparam int SOFT_HOLD = 64;
`ifdef RST_SEQ_WDT_EN
  localparam int WDT_TIMEOUT = 100;
  localparam bit WDT_EN      = 1'b1;
`else
  localparam int WDT_TIMEOUT = 65536;
  localparam bit WDT_EN      = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in, pll_locked, soft_rst_req, wdt_kick;
  logic [STAGES-1:0] rst_n_out;
  logic              seq_done, wdt_fired;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  vcu_rst_seq #(
    .STAGES(STAGES), .STAGE_DLY(STAGE_DLY), .LOCK_FILT(LOCK_FILT),
    .SOFT_HOLD(SOFT_HOLD), .WDT_TIMEOUT(WDT_TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req), .wdt_kick(wdt_kick),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .wdt_fired(wdt_fired)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Model: mode 0 = waiting for lock, 1 = sequencing (release or run),
  // 2 = soft hold. Outputs derive from the edge the sequence started on.
  int m_mode = 0, m_lr = 0, m_ts = 0, m_ss = 0, m_wref = 0;
  bit m_fired = 1'b0, m_in_run, m_exp;
  int n_rel;
  logic [STAGES-1:0] e_mask;
  logic e_done;

  always @(posedge clk_in) begin
    ecnt++;
    if (!rst_in) begin
      m_mode = 0; m_lr = 0; m_fired = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (pll_locked) begin
            m_lr++;
            if (m_lr == LOCK_FILT) begin
              m_mode = 1; m_ts = ecnt; m_lr = 0;
              m_wref = ecnt + STAGES * STAGE_DLY;
            end
          end else m_lr = 0;
        end
        1: begin
          m_in_run = (ecnt - 1 - m_ts) >= STAGES * STAGE_DLY;
          m_exp = WDT_EN && m_in_run && !wdt_kick && (ecnt - m_wref >= WDT_TIMEOUT);
          if (!pll_locked) begin
            m_mode = 0; m_lr = 0;
          end else if (m_exp) begin
            m_mode = 2; m_ss = ecnt; m_fired = 1'b1;
          end else if (soft_rst_req) begin
            m_mode = 2; m_ss = ecnt;
          end else if (m_in_run && wdt_kick)
            m_wref = ecnt;
        end
        default: begin
          if (ecnt - m_ss == SOFT_HOLD) begin
            m_mode = 0; m_lr = 0;
          end
        end
      endcase
    end
    #1;
    e_mask = '0;
    e_done = 1'b0;
    if (rst_in && m_mode == 1) begin
      n_rel = (ecnt - m_ts) / STAGE_DLY + 1;
      if (n_rel > STAGES) n_rel = STAGES;
      for (int i = 0; i < n_rel; i++) e_mask[i] = 1'b1;
      e_done = (ecnt - m_ts) >= STAGES * STAGE_DLY;
    end
    chk("model_rst_n_out", int'(rst_n_out), int'(e_mask));
    chk("model_seq_done", int'(seq_done), int'(e_done));
    chk("model_wdt_fired", int'(wdt_fired), int'(m_fired && rst_in));
  end

  function automatic logic sig(input int idx);
    if (idx < STAGES) return rst_n_out[idx];
    if (idx == STAGES) return seq_done;
    return wdt_fired;
  endfunction

  // Returns the edge number on which output idx is first seen high, or -1.
  task automatic wait_hi(input int idx, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_in);
      #1;
      if (sig(idx)) begin
        at = ecnt;
        break;
      end
    end
  endtask

  int at, g, s, e, n, k;

  initial begin
    rst_in = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0; wdt_kick = 1'b1;
    #2 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_rst_n_out", int'(rst_n_out), 0);
    chk("reset_seq_done", int'(seq_done), 0);
    chk("reset_wdt_fired", int'(wdt_fired), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    pll_locked = 1'b1;
    wait_hi(0, 100, at);          chk("pwr_stage0_edge", at, 25);
    wait_hi(1, 1100, at);         chk("pwr_stage1_edge", at, 1025);
    wait_hi(2, 1100, at);         chk("pwr_stage2_edge", at, 2025);
    wait_hi(STAGES, 1100, at);    chk("pwr_done_edge", at, 3025);

    // Lock loss in RUN, then a glitch during the filter window.
    @(negedge clk_in) pll_locked = 1'b0;
    @(negedge clk_in);
    chk("loss_rst_n_out", int'(rst_n_out), 0);
    chk("loss_seq_done", int'(seq_done), 0);
    pll_locked = 1'b1;
    repeat (10) @(negedge clk_in);
    pll_locked = 1'b0;
    g = ecnt + 1;
    @(negedge clk_in) pll_locked = 1'b1;
    wait_hi(0, 100, at);          chk("glitch_stage0_edge", at, g + 16);
    wait_hi(STAGES, 3100, at);    chk("glitch_done_edge", at, g + 16 + 3000);

    // Soft request in RELEASE after stage 0, with a second pulse inside SOFT.
    @(negedge clk_in) pll_locked = 1'b0;
    @(negedge clk_in) pll_locked = 1'b1;
    g = ecnt;
    wait_hi(0, 100, at);          chk("resync_stage0_edge", at, g + 16);
    @(negedge clk_in) soft_rst_req = 1'b1;
    @(negedge clk_in) soft_rst_req = 1'b0;
    s = ecnt;
    chk("soft_rst_n_out", int'(rst_n_out), 0);
    repeat (20) @(negedge clk_in);
    soft_rst_req = 1'b1;
    @(negedge clk_in) soft_rst_req = 1'b0;
    wait_hi(0, 200, at);          chk("soft_stage0_edge", at, s + 80);
    wait_hi(STAGES, 3100, at);    chk("soft_done_edge", at, s + 80 + 3000);

    // Soft and lock loss together in RUN: lock loss wins, no soft hold.
    @(negedge clk_in) begin soft_rst_req = 1'b1; pll_locked = 1'b0; end
    @(negedge clk_in) begin soft_rst_req = 1'b0; pll_locked = 1'b1; end
    e = ecnt;
    chk("both_rst_n_out", int'(rst_n_out), 0);
    wait_hi(0, 200, at);          chk("both_stage0_edge", at, e + 16);

    // rst_in mid-RELEASE acts without a clock and restarts the filter.
    repeat (100) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("abort_rst_n_out", int'(rst_n_out), 0);
    chk("abort_seq_done", int'(seq_done), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    n = ecnt;
    wait_hi(0, 100, at);          chk("abort_stage0_edge", at, n + 16);

`ifdef RST_SEQ_WDT_EN
    wait_hi(STAGES, 3100, at);    chk("wdt_done_edge", at, n + 16 + 3000);
    @(negedge clk_in) wdt_kick = 1'b0;
    k = ecnt;
    for (int i = 0; i < 5; i++) begin
      repeat (48) @(negedge clk_in);
      wdt_kick = 1'b1;
      k = ecnt + 1;
      @(negedge clk_in) wdt_kick = 1'b0;
    end
    chk("wdt_kicked_fired", int'(wdt_fired), 0);
    chk("wdt_kicked_done", int'(seq_done), 1);
    wait_hi(STAGES + 1, 300, at); chk("wdt_fire_edge", at, k + 100);
    chk("wdt_fire_done", int'(seq_done), 0);
    repeat (200) @(negedge clk_in);
    chk("wdt_sticky", int'(wdt_fired), 1);
    rst_in = 1'b0;
    #1;
    chk("wdt_clear", int'(wdt_fired), 0);
    @(negedge clk_in) rst_in = 1'b1;
    wdt_kick = 1'b1;
`endif

    repeat (3) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: edge %0d reached without completing", ecnt);
    $fatal(1);
  end

endmodule

// File: doc/vcu_rst_seq.md
# vcu_rst_seq

Power-up reset sequencer sitting directly downstream of the system reset synchronizer. It consumes the synchronized active-low system reset and the PLL lock flag, and releases a set of per-subsystem active-low resets in a fixed order with programmable spacing. It also handles runtime soft-reset requests and re-asserts every reset on loss of PLL lock.

## Interface
- STAGES, 3: number of sequenced reset outputs (1..8); bit 0 is released first.
- STAGE_DLY, 1000: cycles between successive stage releases, and from the last release to seq_done (≥1).
- LOCK_FILT, 16: consecutive pll_locked-high samples required before sequencing (≥1).
- SOFT_HOLD, 64: cycles all outputs are held asserted after a soft request (≥1).
- WDT_TIMEOUT, 65536: watchdog timeout in cycles (≥2), used only with RST_SEQ_WDT_EN.
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  asynchronous, active-low reset, driven by the synchronized system reset output.
- pll_locked  input  1  PLL lock indicator, synchronous to clk_in.
- soft_rst_req  input  1  soft reset request, single-cycle pulse or level.
- wdt_kick  input  1  watchdog service pulse.
- rst_n_out  output  STAGES  per-subsystem active-low resets.
- seq_done  output  1  high while in RUN.
- wdt_fired  output  1  sticky watchdog expiry flag.

## Operation
- FSM states: HOLD, RELEASE, RUN, SOFT. The reset state is HOLD.
- HOLD: all rst_n_out are 0. A lock filter counter increments on each edge with pll_locked=1 and clears on pll_locked=0. On the LOCK_FILT-th consecutive high sample, the FSM moves to RELEASE.
- RELEASE: a stage index and a delay counter advance. rst_n_out[0] rises on the edge that enters RELEASE. rst_n_out[k] rises STAGE_DLY edges after rst_n_out[k-1]. STAGE_DLY edges after rst_n_out[STAGES-1] rises, the FSM moves to RUN.
- RUN: all outputs are 1 and seq_done=1.
- SOFT: all outputs are 0 and seq_done=0. After SOFT_HOLD edges the FSM moves to HOLD, and the lock filter restarts from 0.
- Loss of lock: pll_locked=0 in RELEASE or RUN sends the FSM to HOLD on that edge. All outputs drop on that edge.
- Soft requests:
  - soft_rst_req=1 in RELEASE or RUN sends the FSM to SOFT on that edge.
  - It is ignored in HOLD and SOFT; a request held high in SOFT does not extend the hold.
- Priority on the same edge: rst_in, then lock loss, then watchdog expiry, then soft_rst_req.
- Released stages never re-assert individually. Any re-assertion drops all stages simultaneously.
- Counter width is $clog2 of the largest of STAGE_DLY, SOFT_HOLD, LOCK_FILT and WDT_TIMEOUT, plus 1. Counters never wrap: each is cleared on every state change.

## Timing
- rst_in low forces the following immediately, with no clock required: rst_n_out=0, seq_done=0, wdt_fired=0, state HOLD, all counters 0.
- All outputs are registered, so there is no combinational path from inputs to outputs.
- Minimum latency from the first pll_locked-high edge to seq_done is LOCK_FILT + STAGES·STAGE_DLY − 1 edges. With defaults this is 3015.
- Lock loss to all outputs low: 1 edge.
- Soft request to all outputs low: 1 edge.
- rst_in assertion mid-RELEASE aborts the sequence. On release of rst_in, sequencing restarts from HOLD with the filter at 0.

## Configuration
- RST_SEQ_WDT_EN defined:
  - In RUN, a watchdog counter increments each edge and clears when wdt_kick=1.
  - Reaching WDT_TIMEOUT sends the FSM to SOFT and sets wdt_fired=1.
  - wdt_fired stays 1 until rst_in is asserted.
  - The counter clears on leaving RUN.
- RST_SEQ_WDT_EN undefined: wdt_kick is ignored, wdt_fired is tied 0, and no watchdog logic is built. The port list is identical in both builds.

## Structure
- Package vcu_rst_pkg holds:
  - the state enum (HOLD, RELEASE, RUN, SOFT);
  - a cnt_width function returning the clog2-based width;
  - the default parameter constants.
- Sub-module vcu_lock_filt is the consecutive-sample lock filter. It has inputs clk_in, rst_in, clr, pll_locked and output locked_stable; parameter LOCK_FILT.

## Test plan
- Power-up: rst_in low 5 cycles, then high; pll_locked high from cycle 10. Required with defaults:
  - rst_n_out[0] rises at edge 25;
  - [1] rises at edge 1025;
  - [2] rises at edge 2025;
  - seq_done rises at edge 3025.
- Lock glitch during filter: pll_locked drops for 1 cycle after 10 high samples → filter restarts, and release occurs 16 samples after the glitch.
- Lock loss in RUN: pll_locked=0 for 1 cycle → rst_n_out=3'b000 and seq_done=0 on the next edge, then a full resequence.
- Soft request in RELEASE after stage 0 is released:
  - all outputs are 0 for 64 edges;
  - HOLD, then a fresh sequence.
  - A second soft_rst_req pulse during SOFT changes nothing.
- Simultaneous soft_rst_req and lock loss in RUN → HOLD, not SOFT, confirmed by resequencing without the 64-cycle hold.
- With RST_SEQ_WDT_EN and WDT_TIMEOUT=100:
  - no kick for 100 edges in RUN → SOFT entered and wdt_fired=1;
  - a kick every 50 edges → no expiry;
  - wdt_fired clears only on rst_in.
